// File: rtl/mem_bus_arbiter_if.sv
// AHB-Lite master-port signal bundle shared by mem_bus_arbiter and the bus side.
//   master modport : drives HADDR/HTRANS/HWRITE/HSIZE/HWDATA, samples HRDATA/HREADY/HRESP
//   slave  modport : the mirror image, for the memory/bus model
interface mem_bus_arbiter_if #(
    parameter int unsigned COLS = 32
) ();
    logic [COLS-1:0] HADDR;
    logic [1:0]      HTRANS;
    logic            HWRITE;
    logic [2:0]      HSIZE;
    logic [COLS-1:0] HWDATA;
    logic [COLS-1:0] HRDATA;
    logic            HREADY;
    logic            HRESP;

    modport master (
        output HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        input  HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
        output HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-requester arbiter for a single AHB-Lite master port.
// Instruction fetch (if_*) and load/store (ls_*) requesters compete for one
// outstanding word transfer; the winner gets a combinational gnt in IDLE and a
// one-cycle rvalid pulse with rdata/err when the transfer completes.
//   clk, rst      : clock, asynchronous active-low reset
//   if_*          : fetch request/grant/response
//   ls_*          : load/store request/grant/response
//   busy          : a transfer is in flight
//   bus           : AHB-Lite master modport
module mem_bus_arbiter #(
    parameter int unsigned COLS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [COLS-1:0] if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [COLS-1:0] if_rdata,
    output logic            if_err,
    input  logic            ls_req,
    input  logic            ls_we,
    input  logic [COLS-1:0] ls_addr,
    input  logic [COLS-1:0] ls_wdata,
    output logic            ls_gnt,
    output logic            ls_rvalid,
    output logic [COLS-1:0] ls_rdata,
    output logic            ls_err,
    output logic            busy,
    mem_bus_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic       OWN_IF        = 1'b0;
    localparam logic       OWN_LS        = 1'b1;

    state_e          state_q, state_d;
    logic            last_q, last_d;
    logic            owner_q, owner_d;
    logic [COLS-1:0] addr_q, addr_d;
    logic            we_q, we_d;
    logic [COLS-1:0] wdata_q, wdata_d;
    logic [1:0]      htrans_q, htrans_d;
    logic            hwrite_q, hwrite_d;
    logic [COLS-1:0] hwdata_q, hwdata_d;
    logic            if_rvalid_q, if_rvalid_d;
    logic [COLS-1:0] if_rdata_q, if_rdata_d;
    logic            if_err_q, if_err_d;
    logic            ls_rvalid_q, ls_rvalid_d;
    logic [COLS-1:0] ls_rdata_q, ls_rdata_d;
    logic            ls_err_q, ls_err_d;
    logic            busy_q, busy_d;

    logic            if_gnt_c;
    logic            ls_gnt_c;
    logic            win_c;
    logic [COLS-1:0] req_addr_c;
    logic            resp_c;
    logic [COLS-1:0] resp_data_c;
    logic            resp_err_c;

    // State register and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            last_q      <= OWN_IF;
            owner_q     <= OWN_IF;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            htrans_q    <= HTRANS_IDLE;
            hwrite_q    <= 1'b0;
            hwdata_q    <= '0;
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            if_err_q    <= 1'b0;
            ls_rvalid_q <= 1'b0;
            ls_rdata_q  <= '0;
            ls_err_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            htrans_q    <= htrans_d;
            hwrite_q    <= hwrite_d;
            hwdata_q    <= hwdata_d;
            if_rvalid_q <= if_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            if_err_q    <= if_err_d;
            ls_rvalid_q <= ls_rvalid_d;
            ls_rdata_q  <= ls_rdata_d;
            ls_err_q    <= ls_err_d;
            busy_q      <= busy_d;
        end
    end

    // Arbitration, next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        owner_d     = owner_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        htrans_d    = HTRANS_IDLE;
        hwrite_d    = 1'b0;
        hwdata_d    = '0;
        if_rvalid_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        if_err_d    = 1'b0;
        ls_rvalid_d = 1'b0;
        ls_rdata_d  = ls_rdata_q;
        ls_err_d    = 1'b0;
        if_gnt_c    = 1'b0;
        ls_gnt_c    = 1'b0;
        win_c       = OWN_IF;
        req_addr_c  = '0;
        resp_c      = 1'b0;
        resp_data_c = '0;
        resp_err_c  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (if_req || ls_req) begin
                    // Under contention the side that did not win last time goes.
                    win_c      = (if_req && ls_req) ? ~last_q : ls_req;
                    req_addr_c = (win_c == OWN_LS) ? ls_addr : if_addr;
                    if_gnt_c   = (win_c == OWN_IF);
                    ls_gnt_c   = (win_c == OWN_LS);
                    owner_d    = win_c;
                    last_d     = win_c;
                    addr_d     = req_addr_c;
                    we_d       = (win_c == OWN_LS) ? ls_we : 1'b0;
                    wdata_d    = (win_c == OWN_LS) ? ls_wdata : '0;
                    if (req_addr_c[1:0] != 2'b00) begin
                        // Misaligned: never touches the bus, completes with an error.
                        state_d    = ST_RESP;
                        resp_c     = 1'b1;
                        resp_err_c = 1'b1;
                    end else begin
                        state_d  = ST_ADDR;
                        htrans_d = HTRANS_NONSEQ;
                        hwrite_d = we_d;
                    end
                end
            end
            ST_ADDR: begin
                htrans_d = HTRANS_NONSEQ;
                hwrite_d = we_q;
                if (bus.HREADY) begin
                    state_d  = ST_DATA;
                    htrans_d = HTRANS_IDLE;
                    hwrite_d = 1'b0;
                    hwdata_d = we_q ? wdata_q : '0;
                end
            end
            ST_DATA: begin
                hwdata_d = hwdata_q;
                if (bus.HREADY) begin
                    state_d     = ST_RESP;
                    hwdata_d    = '0;
                    resp_c      = 1'b1;
                    resp_err_c  = bus.HRESP;
                    resp_data_c = (we_q || bus.HRESP) ? '0 : bus.HRDATA;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Route the completion to whichever requester owns the transfer.
        if (resp_c) begin
            if (owner_d == OWN_LS) begin
                ls_rvalid_d = 1'b1;
                ls_rdata_d  = resp_data_c;
                ls_err_d    = resp_err_c;
            end else begin
                if_rvalid_d = 1'b1;
                if_rdata_d  = resp_data_c;
                if_err_d    = resp_err_c;
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    // Grants are combinational from IDLE; forced low while reset is held.
    assign if_gnt     = if_gnt_c & rst;
    assign ls_gnt     = ls_gnt_c & rst;

    assign if_rvalid  = if_rvalid_q;
    assign if_rdata   = if_rdata_q;
    assign if_err     = if_err_q;
    assign ls_rvalid  = ls_rvalid_q;
    assign ls_rdata   = ls_rdata_q;
    assign ls_err     = ls_err_q;
    assign busy       = busy_q;

    assign bus.HADDR  = addr_q;
    assign bus.HTRANS = htrans_q;
    assign bus.HWRITE = hwrite_q;
    assign bus.HSIZE  = HSIZE_WORD;
    assign bus.HWDATA = hwdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: a configurable AHB slave model, a
// completion monitor that pops expected responses, and directed scenarios.
module tb_mem_bus_arbiter;

    localparam int unsigned COLS = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            if_req, if_gnt, if_rvalid, if_err;
    logic [COLS-1:0] if_addr, if_rdata;
    logic            ls_req, ls_we, ls_gnt, ls_rvalid, ls_err;
    logic [COLS-1:0] ls_addr, ls_wdata, ls_rdata;
    logic            busy;

    mem_bus_arbiter_if #(.COLS(COLS)) bus ();

    mem_bus_arbiter #(.COLS(COLS)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .if_err    (if_err),
        .ls_req    (ls_req),
        .ls_we     (ls_we),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_gnt    (ls_gnt),
        .ls_rvalid (ls_rvalid),
        .ls_rdata  (ls_rdata),
        .ls_err    (ls_err),
        .busy      (busy),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        owner;
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_mis = 0;
    int          cyc   = 0;

    int          cfg_aw    = 0;
    int          cfg_dw    = 0;
    bit          cfg_err   = 1'b0;
    logic [31:0] cfg_rdata = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // AHB slave model: inserts cfg_aw / cfg_dw wait states, optional two-cycle error.
    initial begin
        int a_cnt;
        int d_cnt;
        bit in_data;
        bit prev_nonseq;
        bit rdy;
        a_cnt = 0; d_cnt = 0; in_data = 1'b0; prev_nonseq = 1'b0;
        bus.HREADY = 1'b1;
        bus.HRESP  = 1'b0;
        bus.HRDATA = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                a_cnt = 0; d_cnt = 0; in_data = 1'b0; prev_nonseq = 1'b0;
                bus.HREADY = 1'b1; bus.HRESP = 1'b0; bus.HRDATA = 32'h0;
            end else begin
                if (in_data && bus.HREADY) in_data = 1'b0;
                if (prev_nonseq && bus.HREADY) begin
                    in_data = 1'b1;
                    d_cnt   = 0;
                    a_cnt   = 0;
                end
                prev_nonseq = (bus.HTRANS == 2'b10);
                if (prev_nonseq) begin
                    bus.HREADY = (a_cnt >= cfg_aw);
                    bus.HRESP  = 1'b0;
                    bus.HRDATA = 32'h0;
                    a_cnt++;
                end else if (in_data) begin
                    rdy        = (d_cnt >= cfg_dw);
                    bus.HREADY = rdy;
                    bus.HRESP  = cfg_err && (d_cnt + 1 >= cfg_dw);
                    bus.HRDATA = rdy ? cfg_rdata : 32'h0BAD_0BAD;
                    d_cnt++;
                end else begin
                    bus.HREADY = 1'b1;
                    bus.HRESP  = 1'b0;
                    bus.HRDATA = 32'h0;
                    a_cnt      = 0;
                end
            end
        end
    end

    // Completion monitor: every rvalid pops the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst && (if_rvalid || ls_rvalid)) begin
                if (if_rvalid && ls_rvalid) chk("rvalid_both", 32'h1, 32'h0);
                if (exp_q.size() == 0) begin
                    chk("spurious_rvalid", 32'h1, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rv_owner", 32'(ls_rvalid), 32'(e.owner));
                    chk("rv_cycle", 32'(cyc), 32'(e.due));
                    chk("rv_rdata", e.owner ? ls_rdata : if_rdata, e.rdata);
                    chk("rv_err", 32'(e.owner ? ls_err : if_err), 32'(e.err));
                    chk("rv_other_err", 32'(e.owner ? if_err : ls_err), 32'h0);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_done();
        int n = 0;
        #2;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            #3;
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("rvalid_timeout", 32'(exp_q.size()), 32'h0);
            exp_q.delete();
        end
    endtask

    // One transfer from one requester; checks grant, bus phases and queues the response.
    task automatic issue(input logic own, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input int aw, input int dw,
                         input bit err, input logic [31:0] rd);
        bit   mis;
        int   lat;
        int   waited;
        exp_t e;
        mis    = (addr[1:0] != 2'b00);
        lat    = mis ? 1 : 3 + aw + dw;
        waited = 0;
        cfg_aw = aw; cfg_dw = dw; cfg_err = err; cfg_rdata = rd;
        if (own) begin
            ls_req = 1'b1; ls_we = we; ls_addr = addr; ls_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        #1;
        while (!(own ? ls_gnt : if_gnt) && waited < 8) begin
            @(negedge clk);
            #1;
            waited++;
        end
        chk("gnt", 32'(own ? ls_gnt : if_gnt), 32'h1);
        chk("gnt_other", 32'(own ? if_gnt : ls_gnt), 32'h0);
        e.owner = own;
        e.err   = mis | err;
        e.rdata = (mis || we || err) ? 32'h0 : rd;
        e.due   = cyc + lat;
        exp_q.push_back(e);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (k == 1) begin
                if_req = 1'b0;
                ls_req = 1'b0;
            end
            #1;
            if (mis) begin
                chk("mis_htrans", 32'(bus.HTRANS), 32'h0);
            end else if (k <= aw + 1) begin
                chk("a_htrans", 32'(bus.HTRANS), 32'h2);
                chk("a_haddr", bus.HADDR, addr);
                chk("a_hwrite", 32'(bus.HWRITE), 32'(we));
            end else if (k <= aw + dw + 2) begin
                chk("d_htrans", 32'(bus.HTRANS), 32'h0);
                chk("d_hwdata", bus.HWDATA, we ? wdata : 32'h0);
            end
            chk("busy", 32'(busy), 32'h1);
        end
        wait_done();
        @(negedge clk);
    endtask

    initial begin
        int   ng;
        int   last_g;
        int   t;
        logic exp_own;
        exp_t e;

        rst = 1'b0;
        if_req = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_htrans", 32'(bus.HTRANS), 32'h0);
        chk("rst_hsize", 32'(bus.HSIZE), 32'h2);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_haddr", bus.HADDR, 32'h0);
        rst = 1'b1;
        @(negedge clk);

        // Zero-wait load, then store with wait states, then misaligned fetch.
        issue(1'b1, 1'b0, 32'h0000_0010, 32'h0, 0, 0, 1'b0, 32'hDEAD_BEEF);
        issue(1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678, 2, 1, 1'b0, 32'h5555_AAAA);
        issue(1'b0, 1'b0, 32'h0000_0006, 32'h0, 0, 0, 1'b0, 32'h1111_2222);

        // Both requesters held: grants alternate LS, IF, LS, IF every 4 cycles.
        cfg_aw = 0; cfg_dw = 0; cfg_err = 1'b0; cfg_rdata = 32'h600D_0000;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h40;
        if_req = 1'b1; if_addr = 32'h100;
        ng = 0; last_g = -1; exp_own = 1'b1; t = 0;
        #1;
        while (ng < 4 && t < 40) begin
            if (if_gnt && ls_gnt) chk("gnt_both", 32'h1, 32'h0);
            if (if_gnt || ls_gnt) begin
                chk("alt_owner", 32'(ls_gnt), 32'(exp_own));
                if (last_g >= 0) chk("gnt_gap", 32'(cyc - last_g), 32'h4);
                last_g  = cyc;
                e.owner = ls_gnt;
                e.rdata = 32'h600D_0000;
                e.err   = 1'b0;
                e.due   = cyc + 3;
                exp_q.push_back(e);
                exp_own = ~exp_own;
                ng++;
            end
            if (ng < 4) begin
                @(negedge clk);
                #1;
                t++;
            end
        end
        chk("alt_count", 32'(ng), 32'h4);
        @(negedge clk);
        if_req = 1'b0; ls_req = 1'b0;
        wait_done();
        @(negedge clk);

        // Two-cycle error response, then normal traffic resumes.
        issue(1'b1, 1'b0, 32'h0000_0040, 32'h0, 0, 1, 1'b1, 32'hFFFF_0000);
        issue(1'b1, 1'b0, 32'h0000_0044, 32'h0, 0, 0, 1'b0, 32'hCAFE_F00D);
        issue(1'b0, 1'b0, 32'h0000_0080, 32'h0, 1, 2, 1'b0, 32'h1357_9BDF);

        // Reset asserted during the data phase of a read.
        cfg_aw = 0; cfg_dw = 0; cfg_err = 1'b0; cfg_rdata = 32'h7777_8888;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h50;
        #1;
        chk("rst_test_gnt", 32'(ls_gnt), 32'h1);
        @(negedge clk);
        ls_req = 1'b0;
        @(negedge clk);
        #1;
        chk("pre_rst_htrans", 32'(bus.HTRANS), 32'h0);
        chk("pre_rst_busy", 32'(busy), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_haddr", bus.HADDR, 32'h0);
        chk("arst_htrans", 32'(bus.HTRANS), 32'h0);
        chk("arst_hwrite", 32'(bus.HWRITE), 32'h0);
        chk("arst_hwdata", bus.HWDATA, 32'h0);
        chk("arst_if_rdata", if_rdata, 32'h0);
        chk("arst_ls_rdata", ls_rdata, 32'h0);
        chk("arst_rvalid", 32'({if_rvalid, ls_rvalid}), 32'h0);
        chk("arst_err", 32'({if_err, ls_err}), 32'h0);
        chk("arst_gnt", 32'({if_gnt, ls_gnt}), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        issue(1'b1, 1'b0, 32'h0000_0060, 32'h0, 0, 0, 1'b0, 32'h2468_ACE0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the single AHB-Lite master port between two requesters: the instruction-fetch path (IF) and the register-file load/store path (LS, the `data2Mem`/`addr2Mem`/`dataFromMem` traffic). The block arbitrates between them and runs a single outstanding word transfer through address and data phases, honouring HREADY wait states and HRESP errors. It returns read data and a completion pulse to the winning requester. It sits between `micro_control`/`reg_file` and the system bus, replacing direct HTRANS/HWRITE generation.

## Interface
- COLS, 32, address and data width
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- if_req  input  1  fetch request; held until if_gnt
- if_addr  input  COLS  fetch word address
- if_gnt  output  1  fetch request accepted this cycle
- if_rvalid  output  1  one-cycle pulse: fetch complete, if_rdata/if_err valid
- if_rdata  output  COLS  fetched word
- if_err  output  1  fetch failed (bus error or misaligned); valid with if_rvalid
- ls_req  input  1  load/store request; held until ls_gnt
- ls_we  input  1  1 = store, 0 = load
- ls_addr  input  COLS  load/store word address
- ls_wdata  input  COLS  store data
- ls_gnt  output  1  load/store request accepted this cycle
- ls_rvalid  output  1  one-cycle pulse: load/store complete (stores included)
- ls_rdata  output  COLS  load data; 0 for stores
- ls_err  output  1  load/store failed; valid with ls_rvalid
- busy  output  1  transfer in flight (state != IDLE)
- HADDR  output  COLS  AHB address
- HTRANS  output  2  AHB transfer type; only 2'b00 IDLE or 2'b10 NONSEQ
- HWRITE  output  1  AHB write
- HSIZE  output  3  constant 3'b010 (word)
- HWDATA  output  COLS  AHB write data
- HRDATA  input  COLS  AHB read data
- HREADY  input  1  AHB ready
- HRESP  input  1  AHB error response

## Operation
- States: IDLE, ADDR, DATA, RESP.
- IDLE:
  - If any request is present, pick a winner, assert its gnt combinationally for that cycle, and latch addr/we/wdata/owner.
  - Next state is ADDR, or RESP if addr[1:0] != 0.
- Arbitration:
  - Single requester: that requester wins.
  - Both requesting: the requester not granted last time wins.
  - The last-owner register resets to IF, so LS wins the first contention.
- ADDR:
  - HTRANS = NONSEQ; HADDR = latched addr; HWRITE = latched we.
  - Held stable until HREADY = 1 at a clock edge, then go to DATA.
- DATA:
  - HTRANS = IDLE; HWDATA = latched wdata when a write, else 0.
  - Wait for HREADY = 1, then capture HRDATA (reads only) and HRESP into registers and go to RESP.
- RESP:
  - Pulse the owner's rvalid.
  - rdata = captured data, or 0 on error or write.
  - err = captured HRESP or misalignment flag.
  - Next state IDLE.
- Misaligned request: no bus activity (HTRANS stays IDLE); completes via RESP with err = 1, rdata = 0.
- HRESP two-cycle error (HREADY = 0/HRESP = 1, then HREADY = 1/HRESP = 1): the error is sampled on the HREADY = 1 edge and completes with err = 1. No retry.
- Non-owner rvalid/err stay 0. rdata outputs hold their value between pulses.
- A request deasserted before its gnt is dropped with no side effects.

## Timing
- Reset (asynchronous, any state): state IDLE, last-owner IF; all outputs 0 (HTRANS 2'b00, HSIZE 3'b010 constant). An in-flight transfer is abandoned with no rvalid.
- Zero-wait transfer:
  - Cycle 0 (IDLE): gnt.
  - Cycle 1: ADDR phase.
  - Cycle 2: DATA phase.
  - Cycle 3: rvalid.
  - Latency from gnt to rvalid is 3 cycles.
- Each HREADY-low cycle in ADDR or DATA adds 1 cycle.
- Misaligned: gnt in cycle 0, rvalid + err in cycle 1.
- Next grant is possible in the cycle after RESP. Back-to-back transfers take 4 cycles each.
- gnt is never asserted outside IDLE, and at most one gnt is asserted per cycle.
- HADDR/HWRITE/HTRANS change only on clock edges and are stable while HREADY = 0.

## Test plan
- LS load from 0x0000_0010, HREADY = 1, HRDATA = 0xDEAD_BEEF in DATA -> ls_gnt in cycle 0; HTRANS = 2'b10, HADDR = 0x10, HWRITE = 0 in cycle 1; ls_rvalid = 1, ls_rdata = 0xDEAD_BEEF, ls_err = 0 in cycle 3.
- LS store 0x1234_5678 to 0x20 with HREADY low for 2 cycles in ADDR and 1 cycle in DATA -> HADDR held at 0x20; HWDATA = 0x1234_5678 throughout DATA; ls_rvalid in cycle 6, ls_rdata = 0.
- if_req and ls_req both held high continuously -> grants alternate LS, IF, LS, IF, each gnt 4 cycles apart; if_rvalid/ls_rvalid never both high.
- IF fetch of 0x0000_0006 -> if_gnt, HTRANS stays 2'b00, next cycle if_rvalid = 1, if_err = 1, if_rdata = 0.
- LS load with two-cycle HRESP error in DATA -> ls_rvalid with ls_err = 1, ls_rdata = 0; next request proceeds normally.
- rst asserted low during DATA of a read -> all outputs 0 immediately (before the next edge); no rvalid after release; fresh request completes in 3 cycles.
